// File: rtl/fir_tap_loader.sv
// fir_tap_loader: coefficient RAM that streams h[0]..h[NTAPS-1] into the FIR tap chain on request,
// holding the FIR sample enable low while the tap set is only partially loaded.
module fir_tap_loader #(
    parameter int NTAPS = 128,
    parameter int TW    = 12,
    parameter int AW    = 7
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cfg_wr,
    input  logic [AW-1:0] i_cfg_addr,
    input  logic [TW-1:0] i_cfg_data,
    output logic          o_wr_err,
    input  logic          i_load,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    input  logic          i_ce,
    output logic          o_ce
);
    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    localparam logic [AW:0] LAST  = (AW+1)'(NTAPS - 1);
    localparam logic [AW:0] LIMIT = (AW+1)'(NTAPS);

    state_t        state, state_nx;
    logic [AW:0]   cnt, rd_addr;
    logic          last, rd_en, wr_ok;
    logic [TW-1:0] ram [2**AW] = '{default: '0};

    always_comb begin
        last     = cnt == LAST;
        state_nx = state == IDLE   ? (i_load ? PRIME : IDLE) :
                   state == PRIME  ? STREAM :
                   state == STREAM ? (last ? IDLE : STREAM) : IDLE;
        rd_en    = state == PRIME || (state == STREAM && !last);
        rd_addr  = state == PRIME ? '0 : cnt + 1'b1;
        wr_ok    = state == IDLE && {1'b0, i_cfg_addr} < LIMIT;
        o_busy   = state != IDLE;
        o_tap_wr = state == STREAM;
        o_ce     = i_ce & ~o_busy;
    end

    // cnt is the index of the tap currently on o_tap; the next one is read a cycle ahead
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            o_tap    <= '0;
            o_done   <= 1'b0;
            o_wr_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= state == STREAM ? cnt + 1'b1 : '0;
            o_done   <= state == STREAM && last;
            o_wr_err <= i_cfg_wr && !wr_ok;
            if (rd_en) o_tap <= ram[rd_addr[AW-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_cfg_wr && wr_ok) ram[i_cfg_addr] <= i_cfg_data;
    end
endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: randomized scoreboard bench; a per-load snapshot model predicts strobe cycles,
// tap values, done/err pulses and the busy window.
module tb_fir_tap_loader;
    localparam int NTAPS = 8;
    localparam int TW    = 12;
    localparam int AW    = 4;

    typedef struct {
        int            cyc;
        logic [TW-1:0] val;
    } tap_t;

    logic          clk = 1'b0, rst_n = 1'b0, cfg_wr = 1'b0, load = 1'b0, ce = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [TW-1:0] cfg_data = '0;
    logic          wr_err, busy, done, tap_wr, ce_out;
    logic [TW-1:0] tap;

    int            cyc = 0, pass = 0, total = 0, ls = 0;
    bit            active = 0, eb, ed, ee;
    logic [TW-1:0] mram [NTAPS] = '{default: '0};
    tap_t          tq[$], t;
    int            dq[$], eq[$];

    fir_tap_loader #(.NTAPS(NTAPS), .TW(TW), .AW(AW)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_cfg_wr(cfg_wr), .i_cfg_addr(cfg_addr),
        .i_cfg_data(cfg_data), .o_wr_err(wr_err), .i_load(load), .o_busy(busy),
        .o_done(done), .o_tap_wr(tap_wr), .o_tap(tap), .i_ce(ce), .o_ce(ce_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit model_busy(int c);
        return active && c >= ls + 1 && c <= ls + NTAPS + 1;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, a, e);
        else pass++;
    endtask

    // one cycle of stimulus; the model decides acceptance from the busy window alone
    task automatic step(bit r, bit w, int a, int d, bit l);
        bit idle;
        @(posedge clk);
        #1;
        rst_n = r; cfg_wr = w; cfg_addr = AW'(a); cfg_data = TW'(d); load = l;
        ce = 1'($urandom);
        if (!r) begin
            active = 0;
            tq.delete(); dq.delete(); eq.delete();
        end else begin
            idle = !model_busy(cyc);
            if (w) begin
                if (idle && a < NTAPS) mram[a] = TW'(d);
                else eq.push_back(cyc + 1);
            end
            if (l && idle) begin
                ls = cyc;
                active = 1;
                for (int k = 0; k < NTAPS; k++) tq.push_back('{cyc + 2 + k, mram[k]});
                dq.push_back(cyc + NTAPS + 2);
            end
        end
    endtask

    task automatic idle_n(int n);
        repeat (n) step(1, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        eb = model_busy(cyc);
        chk("busy", busy, eb);
        chk("ce", ce_out, ce && !eb);
        if (tap_wr) begin
            if (tq.size() == 0) chk("strobe_unexpected", tap_wr, 0);
            else begin
                t = tq.pop_front();
                chk("tap_cyc", cyc, t.cyc);
                chk("tap_val", tap, t.val);
            end
        end else if (tq.size() != 0 && tq[0].cyc <= cyc) begin
            void'(tq.pop_front());
            chk("strobe_missing", tap_wr, 1);
        end
        ed = dq.size() != 0 && dq[0] == cyc;
        if (ed) void'(dq.pop_front());
        chk("done", done, ed);
        ee = eq.size() != 0 && eq[0] == cyc;
        if (ee) void'(eq.pop_front());
        chk("wr_err", wr_err, ee);
        if (!rst_n) chk("rst_tap", tap, 0);
    end

    initial begin
        repeat (3) step(0, 0, 0, 0, 0);
        idle_n(1);
        for (int k = 0; k < NTAPS; k++) step(1, 1, k, k + 1, 0);
        step(1, 0, 0, 0, 1);
        idle_n(12);
        step(1, 0, 0, 0, 1);
        idle_n(2);
        step(1, 1, 3, 'h555, 0);
        idle_n(10);
        step(1, 1, 9, 'h123, 0);
        idle_n(1);
        step(1, 0, 0, 0, 1);
        idle_n(12);
        step(1, 0, 0, 0, 1);
        idle_n(3);
        step(1, 0, 0, 0, 1);
        idle_n(NTAPS - 3);
        step(1, 0, 0, 0, 1);
        idle_n(12);
        step(1, 1, 0, 'h7FF, 1);
        idle_n(12);
        step(1, 0, 0, 0, 1);
        idle_n(4);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle_n(1);
        step(1, 0, 0, 0, 1);
        idle_n(12);
        repeat (400) step(1, $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 4095)), $urandom_range(0, 9) == 0);
        idle_n(15);
        chk("drain", tq.size() + dq.size() + eq.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
